cpu_dump_ctrl: RTL and testbench

- Synthesizable run-and-dump controller for the pipeline CPU; replaces the fixed "print at cycle 30" bench procedure.
- Lets the CPU run for a programmable number of cycles, or until it signals halt, then freezes it.
- Streams the register file and/or data memory contents out over a valid/ready port, one word per cycle.
- Register-file depth, memory depth, data width and counter width are parameters.

---
 rtl/cpu_dump_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_dump_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dump_ctrl.sv
// Run-and-dump controller: runs the CPU for a cycle budget or until halt, then streams RF/DM words.
// Dump valid rises the cycle after the last run cycle; stalls hold index, select and read addresses.
module cpu_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int MEM_N  = 32,
  parameter int CYC_W  = 16,
  parameter int IDX_W  = $clog2((REG_N > MEM_N) ? REG_N : MEM_N)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [CYC_W-1:0]          trig_cycle_i,
  input  logic                      halt_i,
  input  logic [1:0]                dump_mask_i,
  output logic                      cpu_run_o,
  output logic [$clog2(REG_N)-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0]         rf_rdata_i,
  output logic [31:0]               dm_raddr_o,
  input  logic [DATA_W-1:0]         dm_rdata_i,
  output logic                      dump_valid_o,
  input  logic                      dump_ready_i,
  output logic                      dump_sel_o,
  output logic [IDX_W-1:0]          dump_idx_o,
  output logic [DATA_W-1:0]         dump_data_o,
  output logic [CYC_W-1:0]          cycle_cnt_o,
  output logic                      done_o
);

  localparam int RF_AW = $clog2(REG_N);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DUMP_RF = 3'd2,
    DUMP_DM = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       mask_q;
  logic [CYC_W-1:0] cnt_q;

  logic run_exit;
  logic accept;
  logic rf_last;
  logic dm_last;
  logic start_ok;

  // Compare in CYC_W+1 bits so a saturated counter can never re-match the trigger.
  assign run_exit = halt_i ||
                    ((trig_cycle_i != '0) &&
                     (({1'b0, cnt_q} + (CYC_W+1)'(1)) == {1'b0, trig_cycle_i}));
  assign accept   = dump_valid_o && dump_ready_i;
  assign rf_last  = (idx_q == IDX_W'(REG_N - 1));
  assign dm_last  = (idx_q == IDX_W'(MEM_N - 1));
  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (run_exit) begin
          if (mask_q[0])      state_d = DUMP_RF;
          else if (mask_q[1]) state_d = DUMP_DM;
          else                state_d = DONE;
        end
      end
      DUMP_RF: begin
        if (dump_ready_i && rf_last) state_d = mask_q[1] ? DUMP_DM : DONE;
      end
      DUMP_DM: begin
        if (dump_ready_i && dm_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (start_ok) begin
        idx_q  <= '0;
        mask_q <= dump_mask_i;
        cnt_q  <= '0;
      end
      if ((state_q == RUN) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CYC_W'(1);
      end
      if (accept) begin
        if ((state_q == DUMP_RF && rf_last) || (state_q == DUMP_DM && dm_last)) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign cpu_run_o    = (state_q == RUN);
  assign dump_valid_o = (state_q == DUMP_RF) || (state_q == DUMP_DM);
  assign dump_sel_o   = (state_q == DUMP_DM);
  assign done_o       = (state_q == DONE);
  assign dump_idx_o   = idx_q;
  assign cycle_cnt_o  = cnt_q;
  assign rf_raddr_o   = (state_q == DUMP_RF) ? RF_AW'(idx_q) : '0;
  assign dm_raddr_o   = (state_q == DUMP_DM) ? {{(30-IDX_W){1'b0}}, idx_q, 2'b00} : '0;
  // Data is gated so the port reads 0 outside a dump, including under reset.
  assign dump_data_o  = !dump_valid_o ? '0 : (dump_sel_o ? dm_rdata_i : rf_rdata_i);

endmodule

// File: tb/tb_cpu_dump_ctrl.sv
// Bench for cpu_dump_ctrl: directed and randomized run/dump sequences checked against a word-list model.
module tb_cpu_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] rf_img [32];
  logic [31:0] dm_img [32];

  // main instance, default parameters
  logic        start = 1'b0;
  logic [15:0] trig_cycle = '0;
  logic        halt = 1'b0;
  logic [1:0]  mask = '0;
  logic        ready = 1'b1;
  logic        cpu_run;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] dm_raddr;
  logic [31:0] dm_rdata;
  logic        dump_valid;
  logic        dump_sel;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [15:0] cycle_cnt;
  logic        done;

  assign rf_rdata = rf_img[rf_raddr];
  assign dm_rdata = dm_img[dm_raddr[6:2]];

  cpu_dump_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .trig_cycle_i(trig_cycle),
    .halt_i(halt), .dump_mask_i(mask), .cpu_run_o(cpu_run),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .dm_raddr_o(dm_raddr), .dm_rdata_i(dm_rdata),
    .dump_valid_o(dump_valid), .dump_ready_i(ready), .dump_sel_o(dump_sel),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data),
    .cycle_cnt_o(cycle_cnt), .done_o(done)
  );

  // small instance with a 4-bit counter for saturation
  logic        s_start = 1'b0;
  logic [3:0]  s_trig = '0;
  logic        s_halt = 1'b0;
  logic [1:0]  s_mask = '0;
  logic        s_ready = 1'b1;
  logic        s_run;
  logic [1:0]  s_rfa;
  logic [31:0] s_rfd;
  logic [31:0] s_dma;
  logic [31:0] s_dmd;
  logic        s_vld;
  logic        s_sel;
  logic [1:0]  s_idx;
  logic [31:0] s_dat;
  logic [3:0]  s_cnt;
  logic        s_done;

  assign s_rfd = rf_img[{3'b000, s_rfa}];
  assign s_dmd = dm_img[{3'b000, s_dma[3:2]}];

  cpu_dump_ctrl #(.DATA_W(32), .REG_N(4), .MEM_N(4), .CYC_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .trig_cycle_i(s_trig),
    .halt_i(s_halt), .dump_mask_i(s_mask), .cpu_run_o(s_run),
    .rf_raddr_o(s_rfa), .rf_rdata_i(s_rfd),
    .dm_raddr_o(s_dma), .dm_rdata_i(s_dmd),
    .dump_valid_o(s_vld), .dump_ready_i(s_ready), .dump_sel_o(s_sel),
    .dump_idx_o(s_idx), .dump_data_o(s_dat),
    .cycle_cnt_o(s_cnt), .done_o(s_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] cur_word();
    return {dump_sel, dump_idx, (dump_sel ? dm_raddr : {27'b0, rf_raddr}), dump_data};
  endfunction

  // Start a run, count enabled cycles, then capture every accepted word and
  // compare against the list of words the mask says should appear.
  task automatic run_dump(input int trig, input int halt_at, input logic [1:0] m,
                          input bit bp, input bit poke);
    int runs, exp_runs, guard, cyc, k, nwords;
    bit stalled;
    logic [69:0] held;
    logic [69:0] got [$];
    logic [69:0] expq [$];

    exp_runs = (trig != 0 && (halt_at == 0 || trig <= halt_at)) ? trig : halt_at;
    for (int r = 0; r < 32; r++) if (m[0]) expq.push_back({1'b0, 5'(r), 32'(r), rf_img[r]});
    for (int d = 0; d < 32; d++) if (m[1]) expq.push_back({1'b1, 5'(d), 32'(d * 4), dm_img[d]});
    nwords = expq.size();

    @(negedge clk);
    start = 1'b1; mask = m; trig_cycle = 16'(trig);
    @(negedge clk);
    start = 1'b0;
    runs = 0; guard = 0;
    while (cpu_run && guard < 3000) begin
      runs++; guard++;
      halt  = (runs == halt_at);
      start = poke && (runs == 2);
      @(negedge clk);
    end
    halt = 1'b0; start = 1'b0;
    chk("run_cycles", runs, exp_runs);
    chk("cycle_cnt", cycle_cnt, exp_runs);
    chk("valid_after_exit", dump_valid, (m != 2'b00));
    chk("done_after_exit", done, (m == 2'b00));

    cyc = 0; k = 0; stalled = 1'b0; held = '0;
    while (!done && cyc < 3000) begin
      if (stalled) chk("stall_hold", cur_word(), held);
      ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      k++;
      start = poke && (cyc == 3);
      stalled = dump_valid && !ready;
      held = cur_word();
      if (dump_valid && ready) got.push_back(cur_word());
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; ready = 1'b1;
    chk("done_seen", done, 1'b1);
    chk("done_no_run", cpu_run, 1'b0);
    if (!bp) chk("dump_cycles", cyc, nwords);
    chk("word_count", got.size(), nwords);
    for (int i = 0; i < nwords; i++) begin
      if (i < got.size()) chk("word", got[i], expq[i]);
    end
  endtask

  initial begin
    int low, n, g, tr, ha;
    logic [1:0] rm;

    for (int i = 0; i < 32; i++) begin
      rf_img[i] = $urandom;
      dm_img[i] = $urandom;
    end

    #3;
    chk("reset_outputs", {cpu_run, dump_valid, done, dump_sel, dump_idx, rf_raddr,
                          dm_raddr, cycle_cnt, dump_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_quiet", {cpu_run, dump_valid, done}, 3'b000);

    run_dump(30, 0, 2'b01, 1'b0, 1'b0);   // cycle budget, RF only
    run_dump(0, 12, 2'b10, 1'b0, 1'b0);   // halt, DM only
    run_dump(20, 0, 2'b01, 1'b1, 1'b0);   // backpressure
    run_dump(9, 9, 2'b11, 1'b0, 1'b0);    // halt coincides with trigger

    run_dump(5, 0, 2'b00, 1'b0, 1'b0);    // empty mask
    repeat (3) @(negedge clk);
    chk("done_hold_cnt", cycle_cnt, 5);
    chk("done_hold", done, 1'b1);
    run_dump(7, 0, 2'b01, 1'b0, 1'b1);    // restart from DONE, start pokes ignored

    // reset in the middle of the memory section
    @(negedge clk);
    start = 1'b1; mask = 2'b11; trig_cycle = 16'd4;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(dump_valid && dump_sel && dump_idx == 5'd7) && g < 500) begin
      g++;
      @(negedge clk);
    end
    chk("reached_dm7", {dump_valid, dump_sel, dump_idx}, {2'b11, 5'd7});
    #2 rst = 1'b1;
    #1;
    chk("midreset_outputs", {cpu_run, dump_valid, done, dump_sel, dump_idx, rf_raddr,
                             dm_raddr, cycle_cnt, dump_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {cpu_run, dump_valid, done}, 3'b000);
    run_dump(6, 0, 2'b11, 1'b1, 1'b0);

    for (int it = 0; it < 3; it++) begin
      tr = $urandom_range(1, 40);
      ha = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 45) : 0;
      rm = 2'($urandom_range(1, 3));
      run_dump(tr, ha, rm, 1'($urandom_range(0, 1)), 1'b0);
    end

    // saturation on the 4-bit counter instance
    @(negedge clk);
    s_start = 1'b1; s_mask = 2'b11;
    @(negedge clk);
    s_start = 1'b0;
    low = 0;
    repeat (40) begin
      if (!s_run) low++;
      @(negedge clk);
    end
    chk("sat_run_held", low, 0);
    chk("sat_cnt", s_cnt, 15);
    s_halt = 1'b1;
    @(negedge clk);
    s_halt = 1'b0;
    chk("sat_halt_exit", {s_run, s_vld}, 2'b01);
    n = 0; g = 0;
    while (!s_done && g < 100) begin
      if (s_vld) begin
        chk("sat_word", {s_sel, s_idx, s_dat},
            (n < 4) ? {1'b0, 2'(n), rf_img[n]} : {1'b1, 2'(n - 4), dm_img[(n - 4) % 32]});
        n++;
      end
      g++;
      @(negedge clk);
    end
    chk("sat_words", n, 8);
    chk("sat_cnt_frozen", s_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
